rv32i_decode_issue: RTL
=======================

Name: rv32i_decode_issue

Overview:
- Decode/issue stage that produces the operation stream consumed by the RV32I ALU: alu_control, immediate, src2 select, jump code and pc.
- Accepts fetched instructions over a valid/ready handshake and decodes them combinationally.
- Registers the decoded fields into a 2-entry skid buffer that feeds the execute stage.
- Sits between fetch and execute; it is the producing end of the ALU's control interface.

Parameters:
- XLEN, 32, datapath width; only 32 supported.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard all buffered entries (taken branch/jump redirect)
- in_valid  in  1  fetch offers instruction
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  32  instruction address
- out_valid  out  1  decoded entry available
- out_ready  in  1  execute accepts entry
- out_pc  out  32  pc of entry
- out_alu_control  out  4  ADD 0000, SUB 0001, XOR 0010, OR 0011, AND 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001, LUI 1010, AUIPC 1011
- out_imm  out  32  sign-extended immediate
- out_src2_is_imm  out  1  ALU src2 = out_imm, else rs2 data
- out_jump  out  2  00 none, 01 JAL, 10 JALR, 11 conditional branch
- out_funct3  out  3  raw funct3, used for branch sense and load/store size
- out_rs1_addr, out_rs2_addr, out_rd_addr  out  5 each  register indices
- out_reg_write  out  1  rd is written (forced 0 when rd = x0)
- out_illegal  out  1  unsupported opcode/funct

Behaviour:
- Reset (async, rst_n low): both buffer entries invalid; out_valid=0, in_ready=1, every out_* data field = 0.
- Latency: an instruction accepted at edge N appears on out_* after edge N when the buffer was empty.
- Handshake:
  - A transfer occurs on an edge where valid && ready.
  - in_ready is registered and equals !(entry count == 2).
  - out_* hold stable while out_valid && !out_ready.
  - Order is strictly FIFO.
- Buffer: entry count 0..2.
  - Simultaneous push and pop at count 1 keeps the count at 1.
  - Simultaneous push and pop at count 2 cannot occur, because in_ready=0.
- Flush: on an edge with flush=1, count becomes 0 and out_valid=0 next cycle. Any simultaneous input transfer is dropped; in_ready stays per its registered rule. Flush wins over push and pop.
- Decode:
  - R-type 0110011: funct3/funct7[5] select ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
  - OP-IMM 0010011: same set, no SUB.
    - SLLI/SRLI/SRAI: imm = {27'b0, shamt}; funct7 is checked (0000000 or 0100000), else illegal.
  - LUI 0110111 -> LUI, imm = {instr[31:12], 12'b0}.
  - AUIPC 0010111 -> AUIPC with the same imm.
  - JAL 1101111 -> ADD, jump=01, J-imm.
  - JALR 1100111 -> ADD, jump=10, I-imm, src2_is_imm=1.
  - BRANCH 1100011 -> jump=11, reg_write=0, B-imm.
    - BEQ/BNE -> SUB.
    - BLT/BGE -> SLT.
    - BLTU/BGEU -> SLTU.
    - funct3 010/011 is illegal.
  - LOAD 0000011 (I-imm) and STORE 0100011 (S-imm, reg_write=0) -> ADD, src2_is_imm=1.
  - Anything else: illegal=1, reg_write=0, jump=00, alu_control=ADD, imm=0.
- Widths: all immediates sign-extend from bit 31 of instr except shamt and U-type.

Optional Feature:
- Macro ISSUE_PERF_CNT_EN.
- Defined:
  - Adds ports issued_count out 32 and stall_count out 32.
  - issued_count increments on each output transfer.
  - stall_count increments on each cycle with out_valid && !out_ready.
  - Both wrap at 2^32, reset to 0, and are unaffected by flush.
- Undefined: neither the ports nor the counters exist; behaviour is otherwise identical.

Decomposition:
- Package rv32i_pkg holds:
  - the 4-bit ALU operation constants, shared with the ALU;
  - the 7-bit opcode constants;
  - the jump code constants;
  - a packed decoded-entry struct type.
- Sub-module rv32i_imm_gen: combinational immediate generation for I/S/B/U/J/shamt formats.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), out_ready=1 -> next cycle out_valid=1, alu 0000, rs1=1, rs2=2, rd=3, src2_is_imm=0, reg_write=1.
- SRAI x5,x6,3 (0x40335293) -> alu 0111, imm=0x00000003, src2_is_imm=1, rd=5.
- JAL x1,-8 (0xFF9FF0EF) at pc 0x100 -> alu 0000, jump=01, imm=0xFFFFFFF8, out_pc=0x100.
- Three back-to-back instructions with out_ready=0 -> in_ready falls after 2 accepted, third held; releasing out_ready delivers all three in order, none lost or duplicated.
- flush with 2 entries buffered -> out_valid=0 next cycle, in_ready=1; a concurrent in_valid instruction is not delivered.
- 0x00000000 -> out_illegal=1, reg_write=0; rst_n asserted mid-stream -> out_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: ALU op codes (also used by the ALU), opcodes, jump codes, decoded entry.
// No logic; imported by the decode/issue stage and its helpers.
// Backpressure: not applicable.
package rv32i_pkg;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_XOR   = 4'b0010;
   localparam logic [3:0] ALU_OR    = 4'b0011;
   localparam logic [3:0] ALU_AND   = 4'b0100;
   localparam logic [3:0] ALU_SLL   = 4'b0101;
   localparam logic [3:0] ALU_SRL   = 4'b0110;
   localparam logic [3:0] ALU_SRA   = 4'b0111;
   localparam logic [3:0] ALU_SLT   = 4'b1000;
   localparam logic [3:0] ALU_SLTU  = 4'b1001;
   localparam logic [3:0] ALU_LUI   = 4'b1010;
   localparam logic [3:0] ALU_AUIPC = 4'b1011;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   localparam logic [1:0] JMP_NONE   = 2'b00;
   localparam logic [1:0] JMP_JAL    = 2'b01;
   localparam logic [1:0] JMP_JALR   = 2'b10;
   localparam logic [1:0] JMP_BRANCH = 2'b11;

   typedef enum logic [2:0] {
      IMM_ZERO,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J,
      IMM_SHAMT
   } imm_fmt_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [3:0]  alu_control;
      logic [31:0] imm;
      logic        src2_is_imm;
      logic [1:0]  jump;
      logic [2:0]  funct3;
      logic [4:0]  rs1_addr;
      logic [4:0]  rs2_addr;
      logic [4:0]  rd_addr;
      logic        reg_write;
      logic        illegal;
   } dec_entry_t;

endpackage

// File: rtl/fifo.sv
// Generic FIFO with synchronous flush; storage and pointers reset to zero.
// Latency: a pushed word is visible on pop_dat the edge after the push when empty.
// Backpressure: push_rdy is registered and low only while the FIFO holds DEPTH words.
module fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push_vld,
   output logic             push_rdy,
   input  logic [WIDTH-1:0] push_dat,
   output logic             pop_vld,
   input  logic             pop_rdy,
   output logic [WIDTH-1:0] pop_dat
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL    = CW'(DEPTH);
   localparam logic [AW-1:0] LAST_IX = AW'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             rdy_q;
   logic             push, pop;

   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
      return (p == LAST_IX) ? '0 : p + 1'b1;
   endfunction

   assign push     = push_vld && rdy_q && !flush;
   assign pop      = (cnt_q != '0) && pop_rdy && !flush;
   assign push_rdy = rdy_q;
   assign pop_vld  = (cnt_q != '0);
   assign pop_dat  = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) wr_ptr_d = next_ptr(wr_ptr_q);
         if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
         if (push && !pop)      cnt_d = cnt_q + 1'b1;
         else if (pop && !push) cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         rdy_q    <= 1'b1;
      end else begin
         if (push) mem_q[wr_ptr_q] <= push_dat;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         rdy_q    <= (cnt_d != FULL);
      end
   end

endmodule

// File: rtl/rv32i_imm_gen.sv
// Immediate generator for I/S/B/U/J/shamt formats; sign-extends from instr[31] except U and shamt.
// Purely combinational, zero latency; no backpressure.
module rv32i_imm_gen
   import rv32i_pkg::*;
(
   input  logic [31:7] instr_i,
   input  logic [2:0]  fmt_i,
   output logic [31:0] imm_o
);

   imm_fmt_t fmt;
   assign fmt = imm_fmt_t'(fmt_i);

   always_comb begin
      imm_o = '0;
      case (fmt)
         IMM_I:     imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
         IMM_S:     imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         IMM_B:     imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                             instr_i[11:8], 1'b0};
         IMM_U:     imm_o = {instr_i[31:12], 12'b0};
         IMM_J:     imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                             instr_i[30:21], 1'b0};
         IMM_SHAMT: imm_o = {27'b0, instr_i[24:20]};
         default:   imm_o = '0;
      endcase
   end

endmodule

// File: rtl/rv32i_decode_issue.sv
// RV32I decode/issue: decodes fetched words into ALU control and queues them in a 2-entry skid buffer.
// Latency: accepted at edge N, visible on out_* after edge N; in_ready is registered (low when 2 held).
// Backpressure: out_* hold while out_valid && !out_ready. Optional ISSUE_PERF_CNT_EN adds issue/stall counters.
module rv32i_decode_issue
   import rv32i_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [3:0]      out_alu_control,
   output logic [XLEN-1:0] out_imm,
   output logic            out_src2_is_imm,
   output logic [1:0]      out_jump,
   output logic [2:0]      out_funct3,
   output logic [4:0]      out_rs1_addr,
   output logic [4:0]      out_rs2_addr,
   output logic [4:0]      out_rd_addr,
   output logic            out_reg_write,
`ifdef ISSUE_PERF_CNT_EN
   output logic [31:0]     issued_count,
   output logic [31:0]     stall_count,
`endif
   output logic            out_illegal
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [3:0]  alu;
   logic        src2_imm;
   logic [1:0]  jump;
   logic        reg_wr;
   logic        illegal;
   imm_fmt_t    fmt;
   logic [31:0] imm;
   dec_entry_t  entry_in, entry_out;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];

   always_comb begin
      alu      = ALU_ADD;
      src2_imm = 1'b0;
      jump     = JMP_NONE;
      reg_wr   = 1'b0;
      illegal  = 1'b0;
      fmt      = IMM_ZERO;
      case (opcode)
         OPC_OP: begin
            reg_wr = 1'b1;
            case (funct3)
               3'b000:  alu = funct7[5] ? ALU_SUB : ALU_ADD;
               3'b001:  alu = ALU_SLL;
               3'b010:  alu = ALU_SLT;
               3'b011:  alu = ALU_SLTU;
               3'b100:  alu = ALU_XOR;
               3'b101:  alu = funct7[5] ? ALU_SRA : ALU_SRL;
               3'b110:  alu = ALU_OR;
               default: alu = ALU_AND;
            endcase
         end
         OPC_OP_IMM: begin
            reg_wr   = 1'b1;
            src2_imm = 1'b1;
            fmt      = IMM_I;
            case (funct3)
               3'b000:  alu = ALU_ADD;
               3'b010:  alu = ALU_SLT;
               3'b011:  alu = ALU_SLTU;
               3'b100:  alu = ALU_XOR;
               3'b110:  alu = ALU_OR;
               3'b111:  alu = ALU_AND;
               3'b001: begin
                  alu     = ALU_SLL;
                  fmt     = IMM_SHAMT;
                  illegal = (funct7 != 7'b0000000);
               end
               default: begin
                  fmt     = IMM_SHAMT;
                  alu     = funct7[5] ? ALU_SRA : ALU_SRL;
                  illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
               end
            endcase
         end
         OPC_LUI: begin
            alu = ALU_LUI;   src2_imm = 1'b1; reg_wr = 1'b1; fmt = IMM_U;
         end
         OPC_AUIPC: begin
            alu = ALU_AUIPC; src2_imm = 1'b1; reg_wr = 1'b1; fmt = IMM_U;
         end
         OPC_JAL: begin
            jump = JMP_JAL;  reg_wr = 1'b1; fmt = IMM_J;
         end
         OPC_JALR: begin
            jump = JMP_JALR; reg_wr = 1'b1; src2_imm = 1'b1; fmt = IMM_I;
         end
         OPC_BRANCH: begin
            jump = JMP_BRANCH;
            fmt  = IMM_B;
            case (funct3[2:1])
               2'b00:   alu = ALU_SUB;
               2'b10:   alu = ALU_SLT;
               2'b11:   alu = ALU_SLTU;
               default: illegal = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            src2_imm = 1'b1; reg_wr = 1'b1; fmt = IMM_I;
         end
         OPC_STORE: begin
            src2_imm = 1'b1; fmt = IMM_S;
         end
         default: illegal = 1'b1;
      endcase
      // Any unsupported encoding issues as an inert ADD so execute never acts on it.
      if (illegal) begin
         alu      = ALU_ADD;
         src2_imm = 1'b0;
         jump     = JMP_NONE;
         reg_wr   = 1'b0;
         fmt      = IMM_ZERO;
      end
      if (in_instr[11:7] == 5'd0) reg_wr = 1'b0;
   end

   rv32i_imm_gen u_imm_gen (
      .instr_i (in_instr[31:7]),
      .fmt_i   (fmt),
      .imm_o   (imm)
   );

   assign entry_in = '{
      pc:          in_pc,
      alu_control: alu,
      imm:         imm,
      src2_is_imm: src2_imm,
      jump:        jump,
      funct3:      funct3,
      rs1_addr:    in_instr[19:15],
      rs2_addr:    in_instr[24:20],
      rd_addr:     in_instr[11:7],
      reg_write:   reg_wr,
      illegal:     illegal
   };

   fifo #(
      .WIDTH ($bits(dec_entry_t)),
      .DEPTH (2)
   ) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .push_vld (in_valid),
      .push_rdy (in_ready),
      .push_dat (entry_in),
      .pop_vld  (out_valid),
      .pop_rdy  (out_ready),
      .pop_dat  (entry_out)
   );

   assign out_pc          = entry_out.pc;
   assign out_alu_control = entry_out.alu_control;
   assign out_imm         = entry_out.imm;
   assign out_src2_is_imm = entry_out.src2_is_imm;
   assign out_jump        = entry_out.jump;
   assign out_funct3      = entry_out.funct3;
   assign out_rs1_addr    = entry_out.rs1_addr;
   assign out_rs2_addr    = entry_out.rs2_addr;
   assign out_rd_addr     = entry_out.rd_addr;
   assign out_reg_write   = entry_out.reg_write;
   assign out_illegal     = entry_out.illegal;

`ifdef ISSUE_PERF_CNT_EN
   logic [31:0] issued_q, stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issued_q <= '0;
         stall_q  <= '0;
      end else begin
         if (out_valid && out_ready && !flush) issued_q <= issued_q + 32'd1;
         if (out_valid && !out_ready)          stall_q  <= stall_q + 32'd1;
      end
   end

   assign issued_count = issued_q;
   assign stall_count  = stall_q;
`endif

endmodule
